counter_load_clear_multi: RTL and testbench
===========================================

Name: counter_load_clear_multi

Overview:
- Bank of CHANNELS independent loadable-match counters that share one clock and reset.
- Each channel counts enabled increments up to its programmed match value, then either wraps to 0 (wrap mode) or halts (one-shot mode).
- Each channel emits a registered one-cycle done pulse on its terminal event.
- Used as the timer/event-count bank in control blocks that need several programmable terminal counts.

Parameters:
- MAX, 32: count range. Counter width CW = $clog2(MAX). Must be >= 2.
- CHANNELS, 4: number of independent counter channels. Must be >= 1.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_clear  input  CHANNELS  per-channel synchronous clear.
- i_increment  input  CHANNELS  per-channel count enable.
- i_load  input  CHANNELS  per-channel match-value load strobe.
- i_loadval  input  CW  match value, shared by all channels; written to every channel whose i_load bit is set.
- i_oneshot  input  CHANNELS  per-channel mode: 0 = wrap, 1 = one-shot (halt at match).
- o_count  output  CHANNELS*CW  packed counts; channel k occupies bits [k*CW +: CW].
- ow_match  output  CHANNELS  combinational: o_count[k] == match[k].
- o_done  output  CHANNELS  registered one-cycle terminal-event pulse.
- o_halted  output  CHANNELS  registered: one-shot channel has stopped at its match.

Behaviour:
- Reset (asynchronous, i_rst_n low): all counts 0, all match registers 0, o_done 0, o_halted 0. Reset mid-count aborts immediately; there is no recovery state.
- Channels are fully independent. The per-channel description below applies to each k.
- Match register:
  - If i_load[k] is high, match[k] <= i_loadval at the clock edge.
  - The new value is first used for comparison on the following cycle. A same-cycle increment compares against the old match.
  - Load is independent of clear and increment.
- Count next-state, highest priority first:
  1. i_clear[k]: count <= 0, halted <= 0, done <= 0.
  2. i_increment[k] and halted[k]: no change, done <= 0.
  3. i_increment[k] and count == match, wrap mode: count <= 0, done <= 1.
  4. i_increment[k] and count == match, one-shot mode: count holds, halted <= 1, done <= 1.
  5. i_increment[k] otherwise: count <= count + 1 (modulo 2^CW), done <= 0.
  6. No increment: hold count, done <= 0.
- i_oneshot[k] is sampled on the terminal cycle only. Changing it mid-count affects only the next terminal event.
- Boundaries:
  - Match = 0 in wrap mode: the count stays at 0 and o_done pulses on every enabled cycle.
  - Match greater than 2^CW-1 cannot occur (same width).
  - If the count has already passed a newly loaded lower match, it counts up to 2^CW-1, rolls over to 0 with no done pulse, and continues to the match.
- Halted state:
  - A halted channel exits only through clear or reset.
  - Loading a new match does not un-halt the channel.
- o_done is high for exactly one cycle per terminal event.
- Latency:
  - o_done and o_halted go high on the edge after the terminal increment.
  - ow_match is combinational from registered state.

Optional Feature:
- Macro: COUNTER_LOAD_CLEAR_MULTI_WRAPSTAT_EN.
- When defined:
  - Adds output o_evt_count, CHANNELS*8 bits.
  - Each 8-bit field counts that channel's o_done events and saturates at 255.
  - A field is cleared by reset or by i_clear[k].
  - It increments in the same cycle o_done is set.
- When not defined:
  - The port and its registers do not exist.
  - All other behaviour is identical.

Test Plan:
1. Reset then idle (defaults MAX=32, CHANNELS=4): all counts 0, o_done=0, o_halted=0. With i_increment=0 for 10 cycles, the counts hold.
2. Wrap mode, channel 0: load match 5, then hold increment high for 12 cycles. Count runs 0..5 then 0..5. o_done[0] pulses exactly twice, on the edges after the cycles where count==5 with increment high. Other channels stay at 0.
3. One-shot mode, channel 1: load match 3, then increment for 8 cycles. Count stops at 3; o_done[1] pulses once; o_halted[1]=1. Assert i_clear[1]: count 0, halted 0.
4. Clear priority and simultaneous load, channel 2: counting toward match 7, count=4. Assert clear, increment and load (value 2) together. Next cycle count=0 and match=2. After 3 more increments, o_done[2] pulses.
5. Lower match load past the count, channel 3: count=10, load match 4 and keep incrementing. Count runs to 31, rolls to 0 with no done pulse, then reaches 4 and o_done[3] pulses. Assert i_rst_n low mid-count: counts and match reset asynchronously, before the next clock edge.
6. With COUNTER_LOAD_CLEAR_MULTI_WRAPSTAT_EN defined: channel 0 with match 0 in wrap mode, increment for 300 cycles. o_evt_count[7:0] saturates at 255. i_clear[0] returns it to 0.

Source files
------------

// File: rtl/counter_load_clear_multi.sv
// -----------------------------------------------------------------------------
// counter_load_clear_multi
//
// Bank of CHANNELS independent loadable-match counters on a shared clock and
// reset. Each channel counts enabled increments up to its programmed match
// value. On reaching the match, the channel either wraps to 0 or, in one-shot
// mode, halts. Every terminal event produces a registered one-cycle done pulse.
//
// Optional build feature (macro COUNTER_LOAD_CLEAR_MULTI_WRAPSTAT_EN):
//   adds o_evt_count, which holds a saturating 8-bit done-event counter per
//   channel.
//
// Parameters
//   MAX       count range; counter width CW = $clog2(MAX) (MAX >= 2)
//   CHANNELS  number of counter channels (>= 1)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clear      [CHANNELS]     per-channel synchronous clear (highest priority)
//   i_increment  [CHANNELS]     per-channel count enable
//   i_load       [CHANNELS]     per-channel match load strobe
//   i_loadval    [CW]           match value shared by all loading channels
//   i_oneshot    [CHANNELS]     0 = wrap, 1 = halt at match
//   o_count      [CHANNELS*CW]  channel k at [k*CW +: CW]
//   ow_match     [CHANNELS]     combinational count == match
//   o_done       [CHANNELS]     registered one-cycle terminal-event pulse
//   o_halted     [CHANNELS]     registered one-shot halted flag
//   o_evt_count  [CHANNELS*8]   saturating done-event counts (optional)
// -----------------------------------------------------------------------------

// Single counter channel.
module counter_load_clear_multi_lane #(
  parameter int CW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_increment,
  input  logic          i_load,
  input  logic [CW-1:0] i_loadval,
  input  logic          i_oneshot,
  output logic [CW-1:0] o_count,
  output logic          ow_match,
  output logic          o_done,
`ifdef COUNTER_LOAD_CLEAR_MULTI_WRAPSTAT_EN
  output logic [7:0]    o_evt_count,
`endif
  output logic          o_halted
);

  logic [CW-1:0] match_q;
  logic [CW-1:0] count_q, count_d;
  logic          halted_q, halted_d;
  logic          done_q, done_d;

  // Compare against the registered match. A load in the same cycle therefore
  // takes effect only from the next cycle onward.
  assign ow_match = (count_q == match_q);

  always_comb begin
    count_d  = count_q;
    halted_d = halted_q;
    done_d   = 1'b0;
    if (i_clear) begin
      count_d  = '0;
      halted_d = 1'b0;
    end else if (i_increment && !halted_q) begin
      if (ow_match) begin
        done_d = 1'b1;
        // The mode is only looked at here, on the terminal cycle.
        if (i_oneshot) halted_d = 1'b1;
        else           count_d  = '0;
      end else begin
        // Natural CW-bit rollover. This covers a match loaded below the
        // current count: the counter runs through 2^CW-1 -> 0 with no pulse.
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      match_q  <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // The load path is independent of clear and increment.
      if (i_load) match_q <= i_loadval;
      count_q  <= count_d;
      halted_q <= halted_d;
      done_q   <= done_d;
    end
  end

  assign o_count  = count_q;
  assign o_done   = done_q;
  assign o_halted = halted_q;

`ifdef COUNTER_LOAD_CLEAR_MULTI_WRAPSTAT_EN
  logic [7:0] evt_q;

  // Bump on the same edge that raises o_done. Saturate at 255.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     evt_q <= '0;
    else if (i_clear)                 evt_q <= '0;
    else if (done_d && evt_q != 8'hFF) evt_q <= evt_q + 8'd1;
  end

  assign o_evt_count = evt_q;
`endif

endmodule

// Top level: an array of lane instances.
module counter_load_clear_multi #(
  parameter int MAX      = 32,
  parameter int CHANNELS = 4,
  localparam int CW      = $clog2(MAX)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [CHANNELS-1:0]    i_clear,
  input  logic [CHANNELS-1:0]    i_increment,
  input  logic [CHANNELS-1:0]    i_load,
  input  logic [CW-1:0]          i_loadval,
  input  logic [CHANNELS-1:0]    i_oneshot,
  output logic [CHANNELS*CW-1:0] o_count,
  output logic [CHANNELS-1:0]    ow_match,
  output logic [CHANNELS-1:0]    o_done,
`ifdef COUNTER_LOAD_CLEAR_MULTI_WRAPSTAT_EN
  output logic [CHANNELS*8-1:0]  o_evt_count,
`endif
  output logic [CHANNELS-1:0]    o_halted
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    counter_load_clear_multi_lane #(.CW(CW)) u_lane (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clear     (i_clear[k]),
      .i_increment (i_increment[k]),
      .i_load      (i_load[k]),
      .i_loadval   (i_loadval),
      .i_oneshot   (i_oneshot[k]),
      .o_count     (o_count[k*CW +: CW]),
      .ow_match    (ow_match[k]),
      .o_done      (o_done[k]),
`ifdef COUNTER_LOAD_CLEAR_MULTI_WRAPSTAT_EN
      .o_evt_count (o_evt_count[k*8 +: 8]),
`endif
      .o_halted    (o_halted[k])
    );
  end

endmodule

// File: tb/tb_counter_load_clear_multi.sv
module tb_counter_load_clear_multi;
  localparam int CH = 4;
  localparam int CW = 5;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [CH-1:0]     i_clear, i_increment, i_load, i_oneshot;
  logic [CW-1:0]     i_loadval;
  logic [CH*CW-1:0]  o_count;
  logic [CH-1:0]     ow_match, o_done, o_halted;
`ifdef COUNTER_LOAD_CLEAR_MULTI_WRAPSTAT_EN
  logic [CH*8-1:0]   o_evt_count;
`endif

  counter_load_clear_multi #(.MAX(32), .CHANNELS(CH)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_clear),
    .i_increment (i_increment),
    .i_load      (i_load),
    .i_loadval   (i_loadval),
    .i_oneshot   (i_oneshot),
    .o_count     (o_count),
    .ow_match    (ow_match),
    .o_done      (o_done),
`ifdef COUNTER_LOAD_CLEAR_MULTI_WRAPSTAT_EN
    .o_evt_count (o_evt_count),
`endif
    .o_halted    (o_halted)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string          nm;
    logic [CH-1:0]  clr, inc, ld, os;
    logic [CW-1:0]  lv;
    logic [CH*CW-1:0] cnt;
    logic [CH-1:0]  mt, dn, hl;
  } vec_t;

  vec_t vq[$];
  int errs = 0;
  int checks = 0;

  function automatic logic [CH*CW-1:0] pk(input int c0, c1, c2, c3);
    return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  task automatic add(input string nm, input logic [CH-1:0] clr, inc, ld,
                     input int lv, input logic [CH-1:0] os,
                     input logic [CH*CW-1:0] cnt, input logic [CH-1:0] mt, dn, hl);
    vec_t v;
    v.nm = nm; v.clr = clr; v.inc = inc; v.ld = ld; v.lv = CW'(lv); v.os = os;
    v.cnt = cnt; v.mt = mt; v.dn = dn; v.hl = hl;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [CH-1:0] clr, inc, ld, input int lv, input logic [CH-1:0] os);
    i_clear = clr; i_increment = inc; i_load = ld; i_loadval = CW'(lv); i_oneshot = os;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int e;
    int ndone;
    logic d;

    // Test 2: wrap mode on channel 0, match 5, 12 increments.
    add("t2_load", 4'b0000, 4'b0000, 4'b0001, 5, 4'b0000, pk(0,0,0,0), 4'b1110, 4'b0000, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      e = (i + 1) % 6;
      add($sformatf("t2_inc%0d", i), 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, pk(e,0,0,0),
          {3'b111, (e == 5)}, {3'b000, (i == 5 || i == 11)}, 4'b0000);
    end
    // Test 3: one-shot on channel 1, match 3, 8 increments, then clear.
    add("t3_load", 4'b0000, 4'b0000, 4'b0010, 3, 4'b0010, pk(0,0,0,0), 4'b1100, 4'b0000, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      e = (i < 3) ? i + 1 : 3;
      add($sformatf("t3_inc%0d", i), 4'b0000, 4'b0010, 4'b0000, 0, 4'b0010, pk(0,e,0,0),
          {2'b11, (e == 3), 1'b0}, (i == 3) ? 4'b0010 : 4'b0000, (i >= 3) ? 4'b0010 : 4'b0000);
    end
    add("t3_clear", 4'b0010, 4'b0000, 4'b0000, 0, 4'b0010, pk(0,0,0,0), 4'b1100, 4'b0000, 4'b0000);
    // Test 4: channel 2, match 7, count to 4, then clear+inc+load(2) together.
    add("t4_load", 4'b0000, 4'b0000, 4'b0100, 7, 4'b0000, pk(0,0,0,0), 4'b1000, 4'b0000, 4'b0000);
    for (int i = 1; i <= 4; i++)
      add($sformatf("t4_inc%0d", i), 4'b0000, 4'b0100, 4'b0000, 0, 4'b0000, pk(0,0,i,0),
          4'b1000, 4'b0000, 4'b0000);
    add("t4_clr_inc_ld", 4'b0100, 4'b0100, 4'b0100, 2, 4'b0000, pk(0,0,0,0), 4'b1000, 4'b0000, 4'b0000);
    add("t4_post1", 4'b0000, 4'b0100, 4'b0000, 0, 4'b0000, pk(0,0,1,0), 4'b1000, 4'b0000, 4'b0000);
    add("t4_post2", 4'b0000, 4'b0100, 4'b0000, 0, 4'b0000, pk(0,0,2,0), 4'b1100, 4'b0000, 4'b0000);
    add("t4_post3", 4'b0000, 4'b0100, 4'b0000, 0, 4'b0000, pk(0,0,0,0), 4'b1000, 4'b0100, 4'b0000);

    // Test 1: reset state (async, before any edge), then idle.
    i_rst_n = 1'b0;
    drive(4'b0, 4'b0, 4'b0, 0, 4'b0);
    #1;
    chk("rst_count",  32'(o_count),  32'd0);
    chk("rst_done",   32'(o_done),   32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    chk("rst_match",  32'(ow_match), 32'hF);
    tick(); tick();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle%0d_count", i), 32'(o_count), 32'd0);
      chk($sformatf("idle%0d_done", i),  32'(o_done),  32'd0);
    end

    // Tests 2-4 from the table.
    foreach (vq[i]) begin
      drive(vq[i].clr, vq[i].inc, vq[i].ld, int'(vq[i].lv), vq[i].os);
      tick();
      chk({vq[i].nm, "_count"},  32'(o_count),  32'(vq[i].cnt));
      chk({vq[i].nm, "_match"},  32'(ow_match), 32'(vq[i].mt));
      chk({vq[i].nm, "_done"},   32'(o_done),   32'(vq[i].dn));
      chk({vq[i].nm, "_halted"}, 32'(o_halted), 32'(vq[i].hl));
    end

    // Test 5: channel 3 reaches count 10 under match 31, then a lower match of 4 is loaded.
    drive(4'b0000, 4'b0000, 4'b1000, 31, 4'b0000);
    tick();
    drive(4'b0000, 4'b1000, 4'b0000, 0, 4'b0000);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_count10", 32'(o_count[3*CW +: CW]), 32'd10);
    // The load and the increment happen together, and the compare still uses match 31.
    drive(4'b0000, 4'b1000, 4'b1000, 4, 4'b0000);
    tick();
    chk("t5_ld_inc_count", 32'(o_count[3*CW +: CW]), 32'd11);
    chk("t5_ld_inc_done",  32'(o_done), 32'd0);
    drive(4'b0000, 4'b1000, 4'b0000, 0, 4'b0000);
    e = 11;
    ndone = 0;
    for (int i = 0; i < 26; i++) begin
      if (e == 4) begin e = 0; d = 1'b1; end
      else begin e = (e + 1) % 32; d = 1'b0; end
      tick();
      chk($sformatf("t5_step%0d_count", i), 32'(o_count[3*CW +: CW]), 32'(e));
      chk($sformatf("t5_step%0d_done", i),  32'(o_done), d ? 32'h8 : 32'h0);
      if (o_done[3]) ndone++;
    end
    chk("t5_done_total", 32'(ndone), 32'd1);
    tick(); tick();
    chk("t5_pre_rst_count", 32'(o_count[3*CW +: CW]), 32'd2);
    // Assert reset between edges. State must clear without waiting for a clock.
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t5_async_count",  32'(o_count),  32'd0);
    chk("t5_async_match",  32'(ow_match), 32'hF);
    chk("t5_async_halted", 32'(o_halted), 32'd0);
    drive(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    // After reset, match3 is 0. In wrap mode the count stays at 0 and done fires on each enabled cycle.
    drive(4'b0000, 4'b1000, 4'b0000, 0, 4'b0000);
    tick();
    chk("t5_m0_count", 32'(o_count), 32'd0);
    chk("t5_m0_done",  32'(o_done),  32'h8);
    tick();
    chk("t5_m0_done2", 32'(o_done),  32'h8);
    drive(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
    tick();
    chk("t5_m0_idle_done", 32'(o_done), 32'd0);

`ifdef COUNTER_LOAD_CLEAR_MULTI_WRAPSTAT_EN
    // Test 6: channel 0 uses match 0 in wrap mode, and its event count saturates.
    drive(4'b0000, 4'b0001, 4'b0001, 0, 4'b0000);
    tick();
    chk("t6_evt1", 32'(o_evt_count[7:0]), 32'd1);
    for (int i = 1; i < 300; i++) tick();
    chk("t6_evt_sat", 32'(o_evt_count[7:0]), 32'd255);
    chk("t6_done",    32'(o_done[0]), 32'd1);
    drive(4'b0001, 4'b0000, 4'b0000, 0, 4'b0000);
    tick();
    chk("t6_evt_clr", 32'(o_evt_count[7:0]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
